fls_ctrl: RTL and testbench

FLS_CTRL -- requirements
Module: fls_ctrl

---
 rtl/fls_pkg.sv | 9 +
 rtl/fls_tick.sv | 18 +
 rtl/fls_ctrl.sv | 64 ++++++
 tb/tb_fls_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fls_pkg.sv
// fls_pkg: shared state/phase encodings for the Fibonacci-style sequencer
package fls_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fls_state_e;
endpackage

// File: rtl/fls_tick.sv
// fls_tick: free-running 0..PERIOD-1 counter, held at 0 while disabled, ticks on the last count
module fls_tick #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);
  logic [TW-1:0] cnt;
  // count while enabled and wrap on the last value; any disable restarts from 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || cnt == LAST) ? '0 : cnt + 1'b1;
  assign tick = en && cnt == LAST;
endmodule

// File: rtl/fls_ctrl.sv
// fls_ctrl: button/timer driven load-and-step sequencer controller with overflow halt
module fls_ctrl
  import fls_pkg::*;
#(
  parameter int PERIOD = 8,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          auto,
  input  logic          clr,
  input  logic          ovf_in,
  output logic          ld_a,
  output logic          ld_b,
  output logic          step,
  output logic [1:0]    phase,
  output logic [CW-1:0] term_cnt,
  output logic          halt
);
  fls_state_e state, state_d;
  logic en_q, press, tick_en, tick, req, ld_a_d, ld_b_d, step_d;
  assign press   = en & ~en_q;
  assign tick_en = state == RUN && auto && !clr;
  fls_tick #(.PERIOD(PERIOD)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .tick (tick)
  );
  // clr outranks everything; an overflowing step request halts instead of stepping
  always_comb begin
    req     = auto ? tick : press;
    ld_a_d  = !clr && state == IDLE && press;
    ld_b_d  = !clr && state == ONE && press;
    step_d  = !clr && state == RUN && req && !ovf_in;
    state_d = clr ? IDLE
            : ld_a_d ? ONE
            : ld_b_d ? RUN
            : (state == RUN && req && ovf_in) ? HALT
            : state;
  end
  // state, edge-detect history, registered strobes and saturating term counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      en_q     <= 1'b1;
      ld_a     <= 1'b0;
      ld_b     <= 1'b0;
      step     <= 1'b0;
      term_cnt <= '0;
    end else begin
      state    <= state_d;
      en_q     <= en;
      ld_a     <= ld_a_d;
      ld_b     <= ld_b_d;
      step     <= step_d;
      term_cnt <= clr ? '0
                : ((ld_a_d || ld_b_d || step_d) && !(&term_cnt)) ? term_cnt + 1'b1
                : term_cnt;
    end
  assign phase = state;
  assign halt  = state == HALT;
endmodule

// File: tb/tb_fls_ctrl.sv
// tb_fls_ctrl: scoreboard bench for fls_ctrl with directed button/timer scenarios
module tb_fls_ctrl;
  localparam int PERIOD = 8;
  localparam int CW     = 2;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, auto = 1'b0, clr = 1'b0, ovf_in = 1'b0;
  logic ld_a, ld_b, step, halt;
  logic [1:0] phase;
  logic [CW-1:0] term_cnt;
  typedef struct {
    int kind;
    int cnt;
    int ph;
    int at;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int cyc = 0;
  int vectors = 0, miscompares = 0;

  fls_ctrl #(.PERIOD(PERIOD), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .clr(clr), .ovf_in(ovf_in),
    .ld_a(ld_a), .ld_b(ld_b), .step(step), .phase(phase), .term_cnt(term_cnt), .halt(halt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: every strobe must match the oldest expectation in kind, count, phase and cycle
  always @(negedge clk)
    if (rst_n && (ld_a || ld_b || step)) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got ld_a=%0b ld_b=%0b step=%0b at cycle %0d, expected none",
                 ld_a, ld_b, step, cyc);
      end else begin
        e = sbq.pop_front();
        chk("strobe_onehot", int'(ld_a) + int'(ld_b) + int'(step), 1);
        chk("strobe_kind", step ? 2 : ld_b ? 1 : 0, e.kind);
        chk("strobe_term_cnt", int'(term_cnt), e.cnt);
        chk("strobe_phase", int'(phase), e.ph);
        chk("strobe_cycle", cyc, e.at);
      end
    end

  task automatic tick1;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold, input bit exp_strobe, input int kind, input int cnt, input int ph);
    en = 1'b1;
    if (exp_strobe) sbq.push_back('{kind, cnt, ph, cyc + 1});
    repeat (hold) tick1();
    en = 1'b0;
    repeat (3) tick1();
  endtask

  initial begin
    int k;
    repeat (2) tick1();
    chk("rst_phase", int'(phase), 0);
    chk("rst_term_cnt", int'(term_cnt), 0);
    chk("rst_halt", int'(halt), 0);
    chk("rst_strobes", int'(ld_a | ld_b | step), 0);
    rst_n = 1'b1;
    tick1();
    // held button gives a single ld_a
    press(5, 1, 0, 1, 1);
    chk("one_phase", int'(phase), 1);
    chk("one_term_cnt", int'(term_cnt), 1);
    press(1, 1, 1, 2, 2);
    press(1, 1, 2, 3, 2);
    chk("run_phase", int'(phase), 2);
    chk("run_term_cnt", int'(term_cnt), 3);
    chk("run_halt", int'(halt), 0);
    // counter saturates at 3 while steps keep coming
    press(1, 1, 2, 3, 2);
    press(1, 1, 2, 3, 2);
    // timer stepping: five steps 8 cycles apart, presses ignored
    auto = 1'b1;
    k = cyc;
    for (int i = 1; i <= 5; i++) sbq.push_back('{2, 3, 2, k + 8 * i});
    for (int j = 0; j < 40; j++) begin
      en = (j % 6 == 2);
      tick1();
    end
    auto = 1'b0;
    en = 1'b0;
    repeat (3) tick1();
    chk("auto_pending", sbq.size(), 0);
    // overflow halts, then everything is ignored
    ovf_in = 1'b1;
    press(1, 0, 0, 0, 0);
    chk("halt_phase", int'(phase), 3);
    chk("halt_flag", int'(halt), 1);
    chk("halt_term_cnt", int'(term_cnt), 3);
    press(1, 0, 0, 0, 0);
    auto = 1'b1;
    repeat (20) tick1();
    auto = 1'b0;
    ovf_in = 1'b0;
    press(1, 0, 0, 0, 0);
    chk("halt_stays", int'(phase), 3);
    clr = 1'b1;
    tick1();
    clr = 1'b0;
    chk("clr_phase", int'(phase), 0);
    chk("clr_term_cnt", int'(term_cnt), 0);
    chk("clr_halt", int'(halt), 0);
    // clr beats a simultaneous press in ONE
    press(1, 1, 0, 1, 1);
    en = 1'b1;
    clr = 1'b1;
    tick1();
    en = 1'b0;
    clr = 1'b0;
    chk("clrpress_phase", int'(phase), 0);
    chk("clrpress_term_cnt", int'(term_cnt), 0);
    repeat (3) tick1();
    // async reset mid-RUN with the button held
    press(1, 1, 0, 1, 1);
    press(1, 1, 1, 2, 2);
    en = 1'b1;
    sbq.push_back('{2, 3, 2, cyc + 1});
    tick1();
    tick1();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", int'(phase), 0);
    chk("arst_term_cnt", int'(term_cnt), 0);
    chk("arst_halt", int'(halt), 0);
    chk("arst_strobes", int'(ld_a | ld_b | step), 0);
    tick1();
    rst_n = 1'b1;
    repeat (4) tick1();
    en = 1'b0;
    repeat (2) tick1();
    press(1, 1, 0, 1, 1);
    chk("after_rst_phase", int'(phase), 1);
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
